// File: rtl/iob_cache_req_arbiter.sv
// Round-robin arbiter that funnels N_REQ requesters into one cache front-end.
// At most one transaction is outstanding downstream; read data is broadcast.
module iob_cache_req_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cke_i,
    input  logic [N_REQ-1:0]           req_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [DATA_W-1:0]          req_rdata_o,
    output logic [N_REQ-1:0]           req_rvalid_o,
    output logic                       m_avalid_o,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    output logic [DATA_W/8-1:0]        m_wstrb_o,
    input  logic [DATA_W-1:0]          m_rdata_i,
    input  logic                       m_rvalid_i,
    input  logic                       m_ready_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o,
    output logic                       spur_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [N_REQ-1:0]  r_grant;
    logic              r_spur;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic              w_any;
    logic [PTR_W-1:0]  w_win;
    logic [N_REQ-1:0]  w_onehot;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic              w_idle;

    assign w_idle = (r_state == S_IDLE);

    // Round-robin search from ptr+1; scanning backwards leaves the nearest hit.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (req_avalid_i[idx]) begin
                w_any = 1'b1;
                w_win = idx;
            end
        end
    end

    assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

    // Select the winning requester's request fields.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                w_wdata = req_wdata_i[i*DATA_W +: DATA_W];
                w_wstrb = req_wstrb_i[i*STRB_W +: STRB_W];
            end
        end
    end

    // Handshakes toward requesters are gated by cke_i so that a frozen
    // arbiter never signals an acceptance or response it will not record.
    assign req_ready_o  = (w_idle && w_any && cke_i) ? w_onehot : '0;
    assign req_rvalid_o = (r_state == S_WAIT && m_rvalid_i && cke_i)
                        ? r_grant : '0;
    assign req_rdata_o  = m_rdata_i;

    assign m_avalid_o = (r_state == S_ISSUE);
    assign m_addr_o   = r_addr;
    assign m_wdata_o  = r_wdata;
    assign m_wstrb_o  = r_wstrb;
    assign grant_o    = r_grant;
    assign busy_o     = !w_idle;
    assign spur_o     = r_spur;

    // FSM, round-robin pointer, request latches and sticky spurious flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_ptr   <= PTR_W'(N_REQ - 1);
            r_grant <= '0;
            r_spur  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (cke_i) begin
            if (m_rvalid_i && r_state != S_WAIT) begin
                r_spur <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                        r_ptr   <= w_win;
                        r_grant <= w_onehot;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready_i) begin
                        if (|r_wstrb) begin
                            r_state <= S_IDLE;
                            r_grant <= '0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (m_rvalid_i) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/iob_cache_req_arbiter.md
IOB_CACHE_REQ_ARBITER -- requirements
Module: iob_cache_req_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, SHALL set the number of requester ports; legal range 2..4.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; DATA_W/8 strobe bits.
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n_i  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 cke_i  in  1  SHALL be the clock enable; when 0, all registers hold.
REQ-007 req_avalid_i  in  N_REQ  SHALL carry the per-requester request valid, held until accepted.
REQ-008 req_addr_i  in  N_REQ*ADDR_W  SHALL carry the per-requester address; slice i is requester i.
REQ-009 req_wdata_i  in  N_REQ*DATA_W  SHALL carry the per-requester write data.
REQ-010 req_wstrb_i  in  N_REQ*DATA_W/8  SHALL carry the per-requester byte strobes; all-zero means read.
REQ-011 req_ready_o  out  N_REQ  SHALL indicate acceptance of requester i's request.
REQ-012 req_rdata_o  out  DATA_W  SHALL carry read data, broadcast to all requesters.
REQ-013 req_rvalid_o  out  N_REQ  SHALL qualify req_rdata_o for requester i.
REQ-014 m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  SHALL form the request to the cache front-end.
REQ-015 m_rdata_i, m_rvalid_i, m_ready_i  in  DATA_W/1/1  SHALL form the response from the cache front-end.
REQ-016 grant_o  out  N_REQ  SHALL be the one-hot index of the current owner; 0 when idle.
REQ-017 busy_o  out  1  SHALL be 1 whenever the state is not IDLE.
REQ-018 spur_o  out  1  SHALL be a sticky flag set by a response arriving in a state other than WAIT_RD.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_RD; at most one transaction SHALL be outstanding downstream.
REQ-020 IDLE: if any req_avalid_i bit is set, the winner SHALL be the first set bit searching round-robin from ptr+1 (mod N_REQ).
REQ-021 In the IDLE cycle with a winner: req_ready_o[winner]=1 combinationally; all other ready bits 0; addr/wdata/wstrb latched; ptr<=winner; grant_o<=onehot(winner); next state ISSUE.
REQ-022 req_ready_o SHALL be 0 in ISSUE and WAIT_RD for all requesters.
REQ-023 ISSUE: m_avalid_o=1 with latched fields, held stable until m_ready_i=1.
REQ-024 On an ISSUE cycle with m_ready_i=1: nonzero latched wstrb -> IDLE; zero latched wstrb -> WAIT_RD.
REQ-025 WAIT_RD: on m_rvalid_i=1, req_rvalid_o[owner]=1 in the same cycle; req_rdata_o=m_rdata_i; next state IDLE.
REQ-026 req_rdata_o SHALL equal m_rdata_i in all states; req_rvalid_o SHALL be 0 outside WAIT_RD.
REQ-027 m_rvalid_i in IDLE or ISSUE SHALL be dropped (no req_rvalid_o) and SHALL set spur_o.
REQ-028 grant_o SHALL return to 0 on the transition to IDLE.
REQ-029 Latency: request sampled in IDLE at cycle N -> m_avalid_o=1 at N+1; a write accepted at N+1 SHALL allow a new grant at N+2.
REQ-030 A requester SHALL never be granted twice in a row while another requester is asserting req_avalid_i.
REQ-031 With cke_i=0: FSM, ptr, latches and spur_o SHALL hold; combinational outputs SHALL follow the held state.

Reset
REQ-032 rst_n_i=0 at a clock edge SHALL force IDLE, ptr=N_REQ-1 (requester 0 wins first), grant_o=0, spur_o=0, latches=0, regardless of cke_i.
REQ-033 While in IDLE after reset: m_avalid_o=0, busy_o=0, req_ready_o=0, req_rvalid_o=0 until a request is present.
REQ-034 Reset in ISSUE or WAIT_RD SHALL abandon the transaction; a late m_rvalid_i in IDLE SHALL set spur_o only.

Verification
REQ-035 Reset, then req_avalid_i=2'b11 (both reads): req 0 is granted first, m_addr_o=addr0 at N+1; m_ready_i=1 then m_rvalid_i=1, m_rdata_i=0xA5A5A5A5 -> req_rvalid_o=2'b01; req 1 is granted next.
REQ-036 Write from req 1, wstrb=4'hF, data 0x12345678, m_ready_i low for 3 cycles: m_avalid_o is held 4 cycles with stable fields; returns to IDLE without req_rvalid_o.
REQ-037 All requesters continuously asserting (N_REQ=4): grant order is 0,1,2,3,0 across five transactions.
REQ-038 m_rvalid_i=1 pulsed in IDLE: req_rvalid_o stays 0 and spur_o=1 until reset.
REQ-039 rst_n_i=0 for one cycle during WAIT_RD: next cycle busy_o=0, grant_o=0; the next request from req 0 is granted first.
REQ-040 cke_i=0 for 2 cycles in ISSUE with m_ready_i=1: state and m_avalid_o hold; the accept completes on the first cycle with cke_i=1.
